// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_if
//  Description : Control bundle between the multi-cycle control unit and the
//                datapath. It carries the instruction and status inputs, plus
//                every latch enable, mux select, opcode and memory request
//                produced by the controller.
//                  master : the control unit (drives the controls)
//                  slave  : the datapath / memory side (drives Inst, flag,
//                           Mem_Ack)
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;

    logic [31:0] Inst;
    logic        flag;
    logic        Mem_Ack;

    logic        Write_PC;
    logic        Write_IR;
    logic        Write_Reg;
    logic        LA;
    logic        LB;
    logic        LC;
    logic        LF;
    logic        S;
    logic [1:0]  rm_imm_s;
    logic [1:0]  rs_imm_s;
    logic [3:0]  ALU_OP;
    logic [2:0]  SHIFT_OP;
    logic [1:0]  PC_s;
    logic        W_Addr_s;
    logic [1:0]  W_Data_s;
    logic        Mem_Req;
    logic        Mem_Wr;
    logic        Und_Ins;
    logic [2:0]  ST;

    modport master (
        input  Inst, flag, Mem_Ack,
        output Write_PC, Write_IR, Write_Reg, LA, LB, LC, LF, S,
               rm_imm_s, rs_imm_s, ALU_OP, SHIFT_OP, PC_s,
               W_Addr_s, W_Data_s, Mem_Req, Mem_Wr, Und_Ins, ST
    );

    modport slave (
        output Inst, flag, Mem_Ack,
        input  Write_PC, Write_IR, Write_Reg, LA, LB, LC, LF, S,
               rm_imm_s, rs_imm_s, ALU_OP, SHIFT_OP, PC_s,
               W_Addr_s, W_Data_s, Mem_Req, Mem_Wr, Und_Ins, ST
    );

endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multi-cycle control unit. Decodes the 32-bit instruction into
//                DP0/DP1/DP2/LDST/BR/UND classes and sequences the datapath
//                through IDLE/FETCH/DECODE/EXEC/MEM/WB/BR.
//  Ports       : clk  - system clock, everything updates on posedge
//                Rst  - synchronous active-high reset
//                bus  - multicycle_ctrl_if.master: Inst/flag/Mem_Ack in,
//                       all enables, selects, opcodes, memory request,
//                       Und_Ins pulse and current state ST out
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl (
    input  logic              clk,
    input  logic              Rst,
    multicycle_ctrl_if.master bus
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_MEM    = 3'd5;
    localparam logic [2:0] c_ST_BR     = 3'd6;

    // ---------------- instruction class decode ----------------
    logic       w_rd_pc, w_is_dp0, w_is_dp1, w_is_dp2, w_is_dp;
    logic       w_is_ldst, w_is_br, w_is_und, w_load, w_link;
    logic [3:0] w_op, w_alu_dec;
    logic [1:0] w_shtype;

    always_comb begin
        w_op      = bus.Inst[24:21];
        w_shtype  = bus.Inst[6:5];
        w_load    = bus.Inst[20];
        w_link    = bus.Inst[24];
        w_rd_pc   = (bus.Inst[15:12] == 4'hF);
        w_is_dp0  = (bus.Inst[27:25] == 3'b000) && !bus.Inst[4];
        w_is_dp1  = (bus.Inst[27:25] == 3'b000) && bus.Inst[4] && !bus.Inst[7];
        w_is_dp2  = (bus.Inst[27:25] == 3'b001);
        // Writing the PC through DP/LDST is not supported: treated as UND.
        w_is_dp   = (w_is_dp0 || w_is_dp1 || w_is_dp2) && !w_rd_pc;
        w_is_ldst = (bus.Inst[27:25] == 3'b010) && !w_rd_pc;
        w_is_br   = (bus.Inst[27:25] == 3'b101);
        w_is_und  = !(w_is_dp || w_is_ldst || w_is_br);

        // Compare/test ops reuse the arithmetic/logic ALU codes.
        if (w_is_ldst) begin
            w_alu_dec = bus.Inst[23] ? 4'b0100 : 4'b0010;
        end else if (w_is_br) begin
            w_alu_dec = 4'b0000;
        end else begin
            case (w_op)
                4'b1000: w_alu_dec = 4'b0000;
                4'b1001: w_alu_dec = 4'b0001;
                4'b1010: w_alu_dec = 4'b0010;
                4'b1011: w_alu_dec = 4'b0100;
                default: w_alu_dec = w_op;
            endcase
        end
    end

    // ---------------- state register and registered outputs ----------------
    logic [2:0] r_st, w_next_st;
    logic       r_write_pc, r_write_ir, r_write_reg, r_la, r_lb, r_lc, r_lf, r_s;
    logic       r_w_addr_s, r_mem_req, r_mem_wr, r_und_ins;
    logic [1:0] r_rm_imm_s, r_rs_imm_s, r_pc_s, r_w_data_s;
    logic [3:0] r_alu_op;
    logic [2:0] r_shift_op;

    logic       w_write_pc, w_write_ir, w_write_reg, w_la, w_lb, w_lc, w_lf, w_s;
    logic       w_w_addr_s, w_mem_req, w_mem_wr, w_und_ins;
    logic [1:0] w_rm_imm_s, w_rs_imm_s, w_pc_s, w_w_data_s;
    logic [3:0] w_alu_op;
    logic [2:0] w_shift_op;

    always_ff @(posedge clk) begin
        if (Rst) begin
            r_st        <= c_ST_IDLE;
            r_write_pc  <= 1'b0;
            r_write_ir  <= 1'b0;
            r_write_reg <= 1'b0;
            r_la        <= 1'b0;
            r_lb        <= 1'b0;
            r_lc        <= 1'b0;
            r_lf        <= 1'b0;
            r_s         <= 1'b0;
            r_rm_imm_s  <= 2'b00;
            r_rs_imm_s  <= 2'b00;
            r_alu_op    <= 4'b0000;
            r_shift_op  <= 3'b000;
            r_pc_s      <= 2'b00;
            r_w_addr_s  <= 1'b0;
            r_w_data_s  <= 2'b00;
            r_mem_req   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_und_ins   <= 1'b0;
        end else begin
            r_st        <= w_next_st;
            r_write_pc  <= w_write_pc;
            r_write_ir  <= w_write_ir;
            r_write_reg <= w_write_reg;
            r_la        <= w_la;
            r_lb        <= w_lb;
            r_lc        <= w_lc;
            r_lf        <= w_lf;
            r_s         <= w_s;
            r_rm_imm_s  <= w_rm_imm_s;
            r_rs_imm_s  <= w_rs_imm_s;
            r_alu_op    <= w_alu_op;
            r_shift_op  <= w_shift_op;
            r_pc_s      <= w_pc_s;
            r_w_addr_s  <= w_w_addr_s;
            r_w_data_s  <= w_w_data_s;
            r_mem_req   <= w_mem_req;
            r_mem_wr    <= w_mem_wr;
            r_und_ins   <= w_und_ins;
        end
    end

    // Next state, and the outputs belonging to that next state, so the
    // registered outputs are valid for the whole state.
    always_comb begin
        w_next_st   = c_ST_FETCH;
        w_write_pc  = 1'b0;
        w_write_ir  = 1'b0;
        w_write_reg = 1'b0;
        w_la        = 1'b0;
        w_lb        = 1'b0;
        w_lc        = 1'b0;
        w_lf        = 1'b0;
        w_s         = 1'b0;
        w_rm_imm_s  = 2'b00;
        w_rs_imm_s  = 2'b00;
        w_alu_op    = 4'b0000;
        w_shift_op  = 3'b000;
        w_pc_s      = 2'b00;
        w_w_addr_s  = 1'b0;
        w_w_data_s  = 2'b00;
        w_mem_req   = 1'b0;
        w_mem_wr    = 1'b0;
        w_und_ins   = (r_st == c_ST_FETCH) && bus.flag && w_is_und;

        case (r_st)
            c_ST_IDLE:   w_next_st = c_ST_FETCH;
            c_ST_FETCH:  w_next_st = (bus.flag && !w_is_und) ? c_ST_DECODE : c_ST_FETCH;
            c_ST_DECODE: w_next_st = w_is_br ? c_ST_BR : c_ST_EXEC;
            c_ST_EXEC:   w_next_st = w_is_ldst ? c_ST_MEM : c_ST_WB;
            c_ST_MEM: begin
                if (!bus.Mem_Ack) begin
                    w_next_st = c_ST_MEM;
                end else begin
                    w_next_st = w_load ? c_ST_WB : c_ST_FETCH;
                end
            end
            default:     w_next_st = c_ST_FETCH;
        endcase

        case (w_next_st)
            c_ST_FETCH: begin
                w_write_pc = 1'b1;
                w_write_ir = 1'b1;
            end
            c_ST_DECODE: begin
                w_la = 1'b1;
                w_lb = 1'b1;
                w_lc = 1'b1;
            end
            c_ST_EXEC: begin
                w_lf     = 1'b1;
                w_alu_op = w_alu_dec;
                if (w_is_ldst) begin
                    w_rm_imm_s = 2'b10;
                    w_rs_imm_s = 2'b11;
                end else if (w_is_dp2) begin
                    w_rm_imm_s = 2'b01;
                    w_rs_imm_s = 2'b10;
                    w_shift_op = 3'b111;
                    w_s        = bus.Inst[20];
                end else if (w_is_dp1) begin
                    w_rs_imm_s = 2'b01;
                    w_shift_op = {w_shtype, 1'b1};
                    w_s        = bus.Inst[20];
                end else begin
                    w_shift_op = {w_shtype, 1'b0};
                    w_s        = bus.Inst[20];
                end
            end
            c_ST_MEM: begin
                w_mem_req = 1'b1;
                w_mem_wr  = !w_load;
                w_alu_op  = w_alu_dec;
            end
            c_ST_WB: begin
                w_alu_op = w_alu_dec;
                if (w_is_ldst) begin
                    w_write_reg = 1'b1;
                    w_w_data_s  = 2'b01;
                end else begin
                    // TST/TEQ/CMP/CMN only update flags.
                    w_write_reg = !w_op[3] || w_op[2];
                end
            end
            c_ST_BR: begin
                w_write_pc = 1'b1;
                w_pc_s     = 2'b01;
                if (w_link) begin
                    w_write_reg = 1'b1;
                    w_w_addr_s  = 1'b1;
                    w_w_data_s  = 2'b10;
                end
            end
            default: ;
        endcase
    end

    assign bus.ST        = r_st;
    assign bus.Write_PC  = r_write_pc;
    assign bus.Write_IR  = r_write_ir;
    assign bus.Write_Reg = r_write_reg;
    assign bus.LA        = r_la;
    assign bus.LB        = r_lb;
    assign bus.LC        = r_lc;
    assign bus.LF        = r_lf;
    assign bus.S         = r_s;
    assign bus.rm_imm_s  = r_rm_imm_s;
    assign bus.rs_imm_s  = r_rs_imm_s;
    assign bus.ALU_OP    = r_alu_op;
    assign bus.SHIFT_OP  = r_shift_op;
    assign bus.PC_s      = r_pc_s;
    assign bus.W_Addr_s  = r_w_addr_s;
    assign bus.W_Data_s  = r_w_data_s;
    assign bus.Mem_Req   = r_mem_req;
    assign bus.Mem_Wr    = r_mem_wr;
    assign bus.Und_Ins   = r_und_ins;

endmodule
`default_nettype wire
